// File: rtl/assoc_kv_pkg.sv
// assoc_kv_pkg: shared op codes and FSM states for the associative key/value store
package assoc_kv_pkg;
    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_INSERT = 3'd1,
        OP_LOOKUP = 3'd2,
        OP_DELETE = 3'd3,
        OP_CLEAR  = 3'd4,
        OP_FIRST  = 3'd5,
        OP_NEXT   = 3'd6
    } op_e;
    typedef enum logic {IDLE, RESP} state_e;
endpackage

// File: rtl/assoc_kv_match.sv
// assoc_kv_match: parallel key match, lowest free slot, and (ASSOC_KV_ITER_EN) min / min-greater-than search
module assoc_kv_match #(
    parameter int KEY_W = 32,
    parameter int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic [KEY_W-1:0] keys [DEPTH],
    input  logic [DEPTH-1:0] valid,
    input  logic [KEY_W-1:0] key,
`ifdef ASSOC_KV_ITER_EN
    output logic             min_ok,
    output logic [IDX_W-1:0] min_idx,
    output logic             gt_ok,
    output logic [IDX_W-1:0] gt_idx,
`endif
    output logic             hit,
    output logic [IDX_W-1:0] hit_idx,
    output logic             free_ok,
    output logic [IDX_W-1:0] free_idx
);
    // Descending scan so the lowest index wins for the free slot
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free_ok  = 1'b0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && keys[i] == key) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!valid[i]) begin
                free_ok  = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end
`ifdef ASSOC_KV_ITER_EN
    logic [KEY_W-1:0] min_key, gt_key;
    always_comb begin
        min_ok  = 1'b0;
        min_idx = '0;
        min_key = '0;
        gt_ok   = 1'b0;
        gt_idx  = '0;
        gt_key  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (!min_ok || keys[i] < min_key)) begin
                min_ok  = 1'b1;
                min_idx = IDX_W'(i);
                min_key = keys[i];
            end
            if (valid[i] && keys[i] > key && (!gt_ok || keys[i] < gt_key)) begin
                gt_ok  = 1'b1;
                gt_idx = IDX_W'(i);
                gt_key = keys[i];
            end
        end
    end
`endif
endmodule

// File: rtl/assoc_kv_store.sv
// assoc_kv_store: associative key/value store with single-outstanding valid/ready ops
// ASSOC_KV_ITER_EN enables OP_FIRST/OP_NEXT ordered iteration
module assoc_kv_store
    import assoc_kv_pkg::*;
#(
    parameter int KEY_W = 32,
    parameter int DATA_W = 8,
    parameter int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [KEY_W-1:0]  req_key,
    input  logic [DATA_W-1:0] req_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_hit,
    output logic              resp_err,
    output logic [KEY_W-1:0]  resp_key,
    output logic [DATA_W-1:0] resp_data,
    output logic [CNT_W-1:0]  num,
    output logic              full,
    output logic              empty
);
    localparam int IDX_W = $clog2(DEPTH);
    state_e state, next_state;
    logic [KEY_W-1:0] keys [DEPTH];
    logic [DATA_W-1:0] vals [DEPTH];
    logic [DEPTH-1:0] valid, nxt_valid;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic accept, hit, free_ok, wr_en, r_hit, r_err;
    logic [IDX_W-1:0] hit_idx, free_idx, wr_idx;
    logic [KEY_W-1:0] r_key;
    logic [DATA_W-1:0] r_data;
    op_e op;
`ifdef ASSOC_KV_ITER_EN
    logic min_ok, gt_ok;
    logic [IDX_W-1:0] min_idx, gt_idx;
`endif

    assoc_kv_match #(.KEY_W(KEY_W), .DEPTH(DEPTH)) u_match (
        .keys(keys),
        .valid(valid),
        .key(req_key),
`ifdef ASSOC_KV_ITER_EN
        .min_ok(min_ok),
        .min_idx(min_idx),
        .gt_ok(gt_ok),
        .gt_idx(gt_idx),
`endif
        .hit(hit),
        .hit_idx(hit_idx),
        .free_ok(free_ok),
        .free_idx(free_idx)
    );

    assign op         = op_e'(req_op);
    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
    assign accept     = req_valid && req_ready;
    assign num        = cnt;
    assign full       = cnt == CNT_W'(DEPTH);
    assign empty      = cnt == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (state == IDLE) next_state = req_valid ? RESP : IDLE;
        else               next_state = resp_ready ? IDLE : RESP;
    end

    always_comb begin
        nxt_valid = valid;
        nxt_cnt   = cnt;
        wr_en     = 1'b0;
        wr_idx    = free_idx;
        r_hit     = 1'b0;
        r_err     = 1'b0;
        r_key     = req_key;
        r_data    = '0;
        case (op)
            OP_INSERT: begin
                if (hit) begin
                    wr_en  = 1'b1;
                    wr_idx = hit_idx;
                    r_hit  = 1'b1;
                    r_data = vals[hit_idx];
                end else if (free_ok) begin
                    wr_en             = 1'b1;
                    nxt_valid[free_idx] = 1'b1;
                    nxt_cnt           = cnt + CNT_W'(1);
                end else begin
                    r_err = 1'b1;
                end
            end
            OP_LOOKUP: begin
                r_hit  = hit;
                r_data = hit ? vals[hit_idx] : '0;
            end
            OP_DELETE: begin
                r_hit  = hit;
                r_data = hit ? vals[hit_idx] : '0;
                if (hit) begin
                    nxt_valid[hit_idx] = 1'b0;
                    nxt_cnt            = cnt - CNT_W'(1);
                end
            end
            OP_CLEAR: begin
                nxt_valid = '0;
                nxt_cnt   = '0;
                r_hit     = cnt != '0;
            end
`ifdef ASSOC_KV_ITER_EN
            OP_FIRST: begin
                r_hit  = min_ok;
                r_key  = min_ok ? keys[min_idx] : '0;
                r_data = min_ok ? vals[min_idx] : '0;
            end
            OP_NEXT: begin
                r_hit  = gt_ok;
                r_key  = gt_ok ? keys[gt_idx] : '0;
                r_data = gt_ok ? vals[gt_idx] : '0;
            end
`endif
            default: r_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid     <= '0;
            cnt       <= '0;
            resp_hit  <= 1'b0;
            resp_err  <= 1'b0;
            resp_key  <= '0;
            resp_data <= '0;
        end else if (accept) begin
            valid     <= nxt_valid;
            cnt       <= nxt_cnt;
            resp_hit  <= r_hit;
            resp_err  <= r_err;
            resp_key  <= r_key;
            resp_data <= r_data;
        end
    end

    // Payload storage needs no reset: the valid bits gate every read
    always_ff @(posedge clk) begin
        if (accept && wr_en) begin
            keys[wr_idx] <= req_key;
            vals[wr_idx] <= req_data;
        end
    end
endmodule

// File: tb/tb_assoc_kv_store.sv
// tb_assoc_kv_store: directed self-checking bench for assoc_kv_store with DEPTH=4
module tb_assoc_kv_store;
    import assoc_kv_pkg::*;
    logic clk, rst, req_valid, req_ready, resp_valid, resp_ready;
    logic resp_hit, resp_err, full, empty;
    logic [2:0] req_op;
    logic [31:0] req_key, resp_key;
    logic [7:0] req_data, resp_data;
    logic [2:0] num;
    logic o_hit, o_err;
    logic [31:0] o_key;
    logic [7:0] o_data;
    int tests = 0;
    int failed = 0;

    assoc_kv_store #(.KEY_W(32), .DATA_W(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_key(req_key), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_hit(resp_hit), .resp_err(resp_err), .resp_key(resp_key), .resp_data(resp_data),
        .num(num), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input logic [2:0] op, input logic [31:0] key, input logic [7:0] data);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin tests++; failed++; $display("FAIL issue_timeout: req_ready got 0 want 1"); end
        req_valid = 1'b1; req_op = op; req_key = key; req_data = data;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic take;
        int n = 0;
        @(negedge clk);
        while (!resp_valid && n < 20) begin @(negedge clk); n++; end
        if (!resp_valid) begin tests++; failed++; $display("FAIL resp_timeout: resp_valid got 0 want 1"); end
        o_hit = resp_hit; o_err = resp_err; o_key = resp_key; o_data = resp_data;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] key, input logic [7:0] data);
        issue(op, key, data);
        take();
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; req_op = 3'd0; req_key = '0; req_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tests++; if (req_ready !== 1'b1) begin failed++; $display("FAIL rst_req_ready: got %0h want 1", req_ready); end
        tests++; if (resp_valid !== 1'b0) begin failed++; $display("FAIL rst_resp_valid: got %0h want 0", resp_valid); end
        tests++; if (num !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin failed++; $display("FAIL rst_count: num %0d empty %0h full %0h want 0 1 0", num, empty, full); end
        tests++; if (resp_hit !== 1'b0 || resp_err !== 1'b0 || resp_key !== 32'h0 || resp_data !== 8'h0) begin failed++; $display("FAIL rst_resp: hit %0h err %0h key %0h data %0h want all 0", resp_hit, resp_err, resp_key, resp_data); end
    endtask

    task automatic test_insert_lookup;
        do_op(OP_INSERT, 32'h10, 8'hAA);
        tests++; if (o_hit !== 1'b0 || o_err !== 1'b0 || num !== 3'd1) begin failed++; $display("FAIL ins10: hit %0h err %0h num %0d want 0 0 1", o_hit, o_err, num); end
        do_op(OP_LOOKUP, 32'h10, 8'h00);
        tests++; if (o_hit !== 1'b1 || o_data !== 8'hAA) begin failed++; $display("FAIL lkp10: hit %0h data %0h want 1 aa", o_hit, o_data); end
        do_op(OP_LOOKUP, 32'h11, 8'h00);
        tests++; if (o_hit !== 1'b0 || o_data !== 8'h00 || num !== 3'd1 || o_key !== 32'h11) begin failed++; $display("FAIL lkp11: hit %0h data %0h num %0d key %0h want 0 0 1 11", o_hit, o_data, num, o_key); end
    endtask

    task automatic test_overwrite;
        do_op(OP_INSERT, 32'h10, 8'hBB);
        tests++; if (o_hit !== 1'b1 || o_data !== 8'hAA || num !== 3'd1) begin failed++; $display("FAIL ovw10: hit %0h data %0h num %0d want 1 aa 1", o_hit, o_data, num); end
        do_op(OP_LOOKUP, 32'h10, 8'h00);
        tests++; if (o_hit !== 1'b1 || o_data !== 8'hBB) begin failed++; $display("FAIL ovw_lkp: hit %0h data %0h want 1 bb", o_hit, o_data); end
    endtask

    task automatic test_full;
        do_op(OP_CLEAR, 32'h0, 8'h00);
        tests++; if (o_hit !== 1'b1 || num !== 3'd0) begin failed++; $display("FAIL pre_clear: hit %0h num %0d want 1 0", o_hit, num); end
        for (int k = 1; k <= 4; k++) do_op(OP_INSERT, 32'(k), 8'(k));
        tests++; if (full !== 1'b1 || num !== 3'd4 || empty !== 1'b0) begin failed++; $display("FAIL fill: full %0h num %0d empty %0h want 1 4 0", full, num, empty); end
        do_op(OP_INSERT, 32'h5, 8'h05);
        tests++; if (o_err !== 1'b1 || num !== 3'd4) begin failed++; $display("FAIL ins_full: err %0h num %0d want 1 4", o_err, num); end
        do_op(OP_INSERT, 32'h2, 8'h55);
        tests++; if (o_err !== 1'b0 || o_hit !== 1'b1 || o_data !== 8'h02) begin failed++; $display("FAIL ovw_full: err %0h hit %0h data %0h want 0 1 2", o_err, o_hit, o_data); end
    endtask

    task automatic test_delete_clear;
        do_op(OP_DELETE, 32'h2, 8'h00);
        tests++; if (o_hit !== 1'b1 || o_data !== 8'h55 || num !== 3'd3 || full !== 1'b0) begin failed++; $display("FAIL del2: hit %0h data %0h num %0d full %0h want 1 55 3 0", o_hit, o_data, num, full); end
        do_op(OP_DELETE, 32'h2, 8'h00);
        tests++; if (o_hit !== 1'b0 || o_err !== 1'b0 || num !== 3'd3) begin failed++; $display("FAIL del2_again: hit %0h err %0h num %0d want 0 0 3", o_hit, o_err, num); end
        do_op(OP_INSERT, 32'h9, 8'h99);
        tests++; if (o_hit !== 1'b0 || num !== 3'd4 || dut.keys[1] !== 32'h9 || dut.valid[1] !== 1'b1) begin failed++; $display("FAIL ins9_slot1: hit %0h num %0d key1 %0h v1 %0h want 0 4 9 1", o_hit, num, dut.keys[1], dut.valid[1]); end
        do_op(OP_CLEAR, 32'h0, 8'h00);
        tests++; if (o_hit !== 1'b1 || num !== 3'd0 || empty !== 1'b1) begin failed++; $display("FAIL clear: hit %0h num %0d empty %0h want 1 0 1", o_hit, num, empty); end
        do_op(OP_CLEAR, 32'h0, 8'h00);
        tests++; if (o_hit !== 1'b0 || o_err !== 1'b0) begin failed++; $display("FAIL clear_empty: hit %0h err %0h want 0 0", o_hit, o_err); end
        do_op(OP_LOOKUP, 32'h9, 8'h00);
        tests++; if (o_hit !== 1'b0 || o_data !== 8'h00) begin failed++; $display("FAIL lkp_after_clear: hit %0h data %0h want 0 0", o_hit, o_data); end
    endtask

    task automatic test_bad_ops;
        do_op(OP_INSERT, 32'h7, 8'h17);
        do_op(OP_NOP, 32'h7, 8'h00);
        tests++; if (o_err !== 1'b1 || o_hit !== 1'b0 || num !== 3'd1) begin failed++; $display("FAIL nop: err %0h hit %0h num %0d want 1 0 1", o_err, o_hit, num); end
        do_op(3'd7, 32'h7, 8'h00);
        tests++; if (o_err !== 1'b1 || num !== 3'd1) begin failed++; $display("FAIL op7: err %0h num %0d want 1 1", o_err, num); end
        do_op(OP_LOOKUP, 32'h7, 8'h00);
        tests++; if (o_hit !== 1'b1 || o_data !== 8'h17) begin failed++; $display("FAIL op7_nochange: hit %0h data %0h want 1 17", o_hit, o_data); end
    endtask

    task automatic test_hold_reset;
        do_op(OP_INSERT, 32'h42, 8'h77);
        issue(OP_LOOKUP, 32'h42, 8'h00);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++; if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_hit !== 1'b1 || resp_data !== 8'h77 || resp_key !== 32'h42) begin failed++; $display("FAIL hold_c%0d: valid %0h ready %0h hit %0h data %0h key %0h want 1 0 1 77 42", c, resp_valid, req_ready, resp_hit, resp_data, resp_key); end
        end
        #2 rst = 1'b1;
        #1;
        tests++; if (resp_valid !== 1'b0 || num !== 3'd0 || empty !== 1'b1 || req_ready !== 1'b1) begin failed++; $display("FAIL async_rst: valid %0h num %0d empty %0h ready %0h want 0 0 1 1", resp_valid, num, empty, req_ready); end
        @(negedge clk);
        rst = 1'b0;
        do_op(OP_LOOKUP, 32'h42, 8'h00);
        tests++; if (o_hit !== 1'b0 || o_data !== 8'h00) begin failed++; $display("FAIL lkp_after_rst: hit %0h data %0h want 0 0", o_hit, o_data); end
    endtask

    task automatic test_iter;
`ifdef ASSOC_KV_ITER_EN
        do_op(OP_FIRST, 32'h0, 8'h00);
        tests++; if (o_hit !== 1'b0 || o_key !== 32'h0 || o_err !== 1'b0) begin failed++; $display("FAIL first_empty: hit %0h key %0h err %0h want 0 0 0", o_hit, o_key, o_err); end
        do_op(OP_INSERT, 32'h30, 8'hC0);
        do_op(OP_INSERT, 32'h05, 8'h50);
        do_op(OP_INSERT, 32'h20, 8'hA0);
        do_op(OP_FIRST, 32'h0, 8'h00);
        tests++; if (o_hit !== 1'b1 || o_key !== 32'h05 || o_data !== 8'h50) begin failed++; $display("FAIL first: hit %0h key %0h data %0h want 1 5 50", o_hit, o_key, o_data); end
        do_op(OP_NEXT, 32'h05, 8'h00);
        tests++; if (o_hit !== 1'b1 || o_key !== 32'h20 || o_data !== 8'hA0) begin failed++; $display("FAIL next05: hit %0h key %0h data %0h want 1 20 a0", o_hit, o_key, o_data); end
        do_op(OP_NEXT, 32'h20, 8'h00);
        tests++; if (o_hit !== 1'b1 || o_key !== 32'h30 || o_data !== 8'hC0) begin failed++; $display("FAIL next20: hit %0h key %0h data %0h want 1 30 c0", o_hit, o_key, o_data); end
        do_op(OP_NEXT, 32'h30, 8'h00);
        tests++; if (o_hit !== 1'b0 || o_key !== 32'h0 || o_data !== 8'h00) begin failed++; $display("FAIL next30: hit %0h key %0h data %0h want 0 0 0", o_hit, o_key, o_data); end
`else
        do_op(OP_INSERT, 32'h30, 8'hC0);
        do_op(OP_FIRST, 32'h0, 8'h00);
        tests++; if (o_err !== 1'b1 || o_hit !== 1'b0) begin failed++; $display("FAIL first_disabled: err %0h hit %0h want 1 0", o_err, o_hit); end
        do_op(OP_NEXT, 32'h0, 8'h00);
        tests++; if (o_err !== 1'b1 || num !== 3'd1) begin failed++; $display("FAIL next_disabled: err %0h num %0d want 1 1", o_err, num); end
`endif
    endtask

    initial begin
        test_reset();
        test_insert_lookup();
        test_overwrite();
        test_full();
        test_delete_clear();
        test_bad_ops();
        test_hold_reset();
        test_iter();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
